// File: rtl/tage_index_gen_if.sv
// Fetch, history-push, redirect, predict and update signals between the
// fetch front end and one TAGE tagged-table index generator.
interface tage_index_gen_if #(
  parameter int INSTR_PER_FETCH = 4,
  parameter int ENTRIES         = 64,
  parameter int TAG_BITS        = 8,
  parameter int HIST_LEN        = 16,
  parameter int VADDR_WIDTH     = 32
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic                                     fetch_valid_i;
  logic [VADDR_WIDTH-1:0]                   fetch_pc_i;
  logic                                     push_valid_i;
  logic                                     push_taken_i;
  logic                                     redirect_valid_i;
  logic [HIST_LEN-1:0]                      redirect_ghr_i;
  logic                                     redirect_taken_i;
  logic                                     predict_valid_o;
  logic [INSTR_PER_FETCH-1:0][IDX_W-1:0]    predict_idx_o;
  logic [INSTR_PER_FETCH-1:0][TAG_BITS-1:0] predict_tag_o;
  logic [HIST_LEN-1:0]                      ghr_o;
  logic [VADDR_WIDTH-1:0]                   update_pc_i;
  logic [HIST_LEN-1:0]                      update_ghr_i;
  logic [IDX_W-1:0]                         update_idx_o;
  logic [TAG_BITS-1:0]                      update_tag_o;

  modport master (
    output fetch_valid_i, fetch_pc_i, push_valid_i, push_taken_i,
           redirect_valid_i, redirect_ghr_i, redirect_taken_i,
           update_pc_i, update_ghr_i,
    input  predict_valid_o, predict_idx_o, predict_tag_o, ghr_o,
           update_idx_o, update_tag_o
  );

  modport slave (
    input  fetch_valid_i, fetch_pc_i, push_valid_i, push_taken_i,
           redirect_valid_i, redirect_ghr_i, redirect_taken_i,
           update_pc_i, update_ghr_i,
    output predict_valid_o, predict_idx_o, predict_tag_o, ghr_o,
           update_idx_o, update_tag_o
  );
endinterface

// File: rtl/tage_index_gen.sv
// TAGE tagged-table index/tag generator: speculative GHR with incrementally
// folded histories, registered per-slot predict hash, combinational update hash.
module tage_index_gen #(
  parameter int INSTR_PER_FETCH = 4,
  parameter int ENTRIES         = 64,
  parameter int TAG_BITS        = 8,
  parameter int HIST_LEN        = 16,
  parameter int VADDR_WIDTH     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  tage_index_gen_if.slave  bus
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int FW    = (IDX_W > TAG_BITS) ? IDX_W : TAG_BITS;

  typedef logic [FW-1:0] fold_t;

  function automatic fold_t fold_w(input logic [HIST_LEN-1:0] h, input int w);
    fold_t r;
    r = '0;
    for (int j = 0; j < HIST_LEN; j++) begin
      r[j % w] = r[j % w] ^ h[j];
    end
    return r;
  endfunction

  // Rotate left within w bits, inject the new bit at 0 and cancel the bit
  // that just aged out of the history window.
  function automatic fold_t shift_w(input fold_t f, input int w, input logic b, input logic o);
    fold_t r;
    r = '0;
    for (int k = 0; k < FW; k++) begin
      if (k < w) begin
        r[k] = f[(k + w - 1) % w];
      end else begin
        r[k] = 1'b0;
      end
    end
    r[0]            = r[0] ^ b;
    r[HIST_LEN % w] = r[HIST_LEN % w] ^ o;
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] hash_idx(input logic [VADDR_WIDTH-1:0] pc,
                                                input logic [IDX_W-1:0] fi);
    return pc[2 +: IDX_W] ^ fi;
  endfunction

  function automatic logic [TAG_BITS-1:0] hash_tag(input logic [VADDR_WIDTH-1:0] pc,
                                                   input logic [TAG_BITS-1:0] ft,
                                                   input logic [TAG_BITS-2:0] ft2);
    return pc[2+IDX_W +: TAG_BITS] ^ ft ^ {ft2, 1'b0};
  endfunction

  logic [HIST_LEN-1:0]                      ghr_r, ghr_n_s;
  logic [IDX_W-1:0]                         f_i_r, f_i_n_s;
  logic [TAG_BITS-1:0]                      f_t_r, f_t_n_s;
  logic [TAG_BITS-2:0]                      f_t2_r, f_t2_n_s;
  logic [VADDR_WIDTH-1:0]                   slot_pc_s [INSTR_PER_FETCH];
  logic [INSTR_PER_FETCH-1:0][IDX_W-1:0]    slot_idx_s, pred_idx_r;
  logic [INSTR_PER_FETCH-1:0][TAG_BITS-1:0] slot_tag_s, pred_tag_r;
  logic                                     pred_valid_r;

  // Next history and folds: redirect recomputes from scratch, push updates incrementally.
  always_comb begin
    ghr_n_s  = ghr_r;
    f_i_n_s  = f_i_r;
    f_t_n_s  = f_t_r;
    f_t2_n_s = f_t2_r;
    if (bus.redirect_valid_i) begin
      ghr_n_s  = {bus.redirect_ghr_i[HIST_LEN-2:0], bus.redirect_taken_i};
      f_i_n_s  = IDX_W'(fold_w(ghr_n_s, IDX_W));
      f_t_n_s  = TAG_BITS'(fold_w(ghr_n_s, TAG_BITS));
      f_t2_n_s = (TAG_BITS-1)'(fold_w(ghr_n_s, TAG_BITS - 1));
    end else if (bus.push_valid_i) begin
      ghr_n_s  = {ghr_r[HIST_LEN-2:0], bus.push_taken_i};
      f_i_n_s  = IDX_W'(shift_w(fold_t'(f_i_r), IDX_W, bus.push_taken_i, ghr_r[HIST_LEN-1]));
      f_t_n_s  = TAG_BITS'(shift_w(fold_t'(f_t_r), TAG_BITS, bus.push_taken_i, ghr_r[HIST_LEN-1]));
      f_t2_n_s = (TAG_BITS-1)'(shift_w(fold_t'(f_t2_r), TAG_BITS - 1, bus.push_taken_i,
                                       ghr_r[HIST_LEN-1]));
    end else begin
      ghr_n_s  = ghr_r;
    end
  end

  // Per-slot hash of the fetch block against the current (pre-update) folds.
  always_comb begin
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      slot_pc_s[i]  = bus.fetch_pc_i + (VADDR_WIDTH'(i) << 2);
      slot_idx_s[i] = hash_idx(slot_pc_s[i], f_i_r);
      slot_tag_s[i] = hash_tag(slot_pc_s[i], f_t_r, f_t2_r);
    end
  end

  // History and folded-history state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ghr_r  <= '0;
      f_i_r  <= '0;
      f_t_r  <= '0;
      f_t2_r <= '0;
    end else begin
      ghr_r  <= ghr_n_s;
      f_i_r  <= f_i_n_s;
      f_t_r  <= f_t_n_s;
      f_t2_r <= f_t2_n_s;
    end
  end

  // Predict output registers; a same-cycle redirect squashes valid only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pred_valid_r <= 1'b0;
      pred_idx_r   <= '0;
      pred_tag_r   <= '0;
    end else begin
      pred_valid_r <= bus.fetch_valid_i & ~bus.redirect_valid_i;
      if (bus.fetch_valid_i) begin
        pred_idx_r <= slot_idx_s;
        pred_tag_r <= slot_tag_s;
      end
    end
  end

  assign bus.predict_valid_o = pred_valid_r;
  assign bus.predict_idx_o   = pred_idx_r;
  assign bus.predict_tag_o   = pred_tag_r;
  assign bus.ghr_o           = ghr_r;

  // Stateless update hash from the retiring branch's checkpointed history.
  assign bus.update_idx_o = hash_idx(bus.update_pc_i, IDX_W'(fold_w(bus.update_ghr_i, IDX_W)));
  assign bus.update_tag_o = hash_tag(bus.update_pc_i,
                                     TAG_BITS'(fold_w(bus.update_ghr_i, TAG_BITS)),
                                     (TAG_BITS-1)'(fold_w(bus.update_ghr_i, TAG_BITS - 1)));
endmodule

// File: tb/tb_tage_index_gen.sv
// Bench for tage_index_gen: directed vector table, random run against a
// bit-queue history model, and asynchronous reset mid-stream.
module tb_tage_index_gen;
  localparam int NS  = 4;
  localparam int ENT = 64;
  localparam int TB  = 8;
  localparam int HL  = 16;
  localparam int VW  = 32;
  localparam int IW  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tage_index_gen_if #(.INSTR_PER_FETCH(NS), .ENTRIES(ENT), .TAG_BITS(TB),
                      .HIST_LEN(HL), .VADDR_WIDTH(VW)) bus ();

  tage_index_gen #(.INSTR_PER_FETCH(NS), .ENTRIES(ENT), .TAG_BITS(TB),
                   .HIST_LEN(HL), .VADDR_WIDTH(VW)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus));

  int nchecks = 0;
  int nerr    = 0;

  bit m_hist[$];  // newest outcome at index 0
  int m_idx[NS];
  int m_tag[NS];
  bit m_pv;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [HL-1:0] ghr_val();
    logic [HL-1:0] v = '0;
    for (int j = 0; j < HL; j++) v[j] = m_hist[j];
    return v;
  endfunction

  function automatic int mfold(input logic [HL-1:0] h, input int w);
    int r = 0;
    for (int j = 0; j < HL; j++) if (h[j]) r = r ^ (1 << (j % w));
    return r;
  endfunction

  function automatic int ref_idx(input logic [31:0] pc, input logic [HL-1:0] g);
    return int'((pc >> 2) % ENT) ^ mfold(g, IW);
  endfunction

  function automatic int ref_tag(input logic [31:0] pc, input logic [HL-1:0] g);
    return int'((pc >> (2 + IW)) % 256) ^ mfold(g, TB) ^ ((mfold(g, TB - 1) << 1) % 256);
  endfunction

  task automatic model_reset();
    m_hist.delete();
    for (int j = 0; j < HL; j++) m_hist.push_back(1'b0);
    m_pv = 1'b0;
    for (int i = 0; i < NS; i++) begin m_idx[i] = 0; m_tag[i] = 0; end
  endtask

  task automatic set_idle();
    bus.fetch_valid_i = 1'b0;    bus.fetch_pc_i = '0;
    bus.push_valid_i = 1'b0;     bus.push_taken_i = 1'b0;
    bus.redirect_valid_i = 1'b0; bus.redirect_ghr_i = '0; bus.redirect_taken_i = 1'b0;
    bus.update_pc_i = '0;        bus.update_ghr_i = '0;
  endtask

  // Advance the model with the currently driven inputs, then clock the DUT.
  task automatic tick();
    logic [HL-1:0] g = ghr_val();
    if (bus.fetch_valid_i) begin
      for (int i = 0; i < NS; i++) begin
        m_idx[i] = ref_idx(bus.fetch_pc_i + 32'(4 * i), g);
        m_tag[i] = ref_tag(bus.fetch_pc_i + 32'(4 * i), g);
      end
    end
    m_pv = bus.fetch_valid_i & ~bus.redirect_valid_i;
    if (bus.redirect_valid_i) begin
      m_hist.delete();
      for (int j = 0; j < HL; j++) m_hist.push_back(bus.redirect_ghr_i[j]);
      m_hist.push_front(bus.redirect_taken_i);
      void'(m_hist.pop_back());
    end else if (bus.push_valid_i) begin
      m_hist.push_front(bus.push_taken_i);
      void'(m_hist.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    logic [HL-1:0] g = ghr_val();
    chk("ghr", 64'(bus.ghr_o), 64'(g));
    chk("pvalid", 64'(bus.predict_valid_o), 64'(m_pv));
    for (int i = 0; i < NS; i++) begin
      chk($sformatf("idx%0d", i), 64'(bus.predict_idx_o[i]), 64'(m_idx[i]));
      chk($sformatf("tag%0d", i), 64'(bus.predict_tag_o[i]), 64'(m_tag[i]));
    end
    chk("fold_i", 64'(dut.f_i_r), 64'(mfold(g, IW)));
    chk("fold_t", 64'(dut.f_t_r), 64'(mfold(g, TB)));
    chk("fold_t2", 64'(dut.f_t2_r), 64'(mfold(g, TB - 1)));
  endtask

  typedef struct {
    bit          redir;
    logic [15:0] rghr;
    bit          rtaken;
    bit          push;
    bit          ptaken;
    bit          fetch;
    logic [31:0] pc;
    int          reps;
    logic [15:0] e_ghr;
    bit          e_pv;
    bit          chk_idx;
    logic [7:0]  e_idx0;
    logic [7:0]  e_tag0;
    logic [7:0]  e_idx1;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic [31:0] pc;
    vt[0] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1,  16'h0000, 1'b1, 1'b1, 8'h00, 8'h00, 8'h01};
    vt[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1,  16'h0001, 1'b0, 1'b1, 8'h00, 8'h00, 8'h01};
    vt[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1,  16'h0001, 1'b1, 1'b1, 8'h01, 8'h03, 8'h00};
    vt[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 15, 16'hFFFF, 1'b0, 1'b1, 8'h01, 8'h03, 8'h00};
    vt[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1,  16'hFFFF, 1'b1, 1'b1, 8'h0F, 8'h06, 8'h0E};
    vt[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1,  16'hFFFF, 1'b0, 1'b1, 8'h0F, 8'h06, 8'h0E};
    vt[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1,  16'hFFFF, 1'b1, 1'b1, 8'h0F, 8'h06, 8'h0E};
    vt[7] = '{1'b1, 16'h00A5, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 1,  16'h014A, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vt[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1,  16'h014A, 1'b1, 1'b1, 8'h0F, 8'hDB, 8'h0E};

    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pvalid", 64'(bus.predict_valid_o), 64'd0);
    chk("rst_ghr", 64'(bus.ghr_o), 64'd0);
    chk("rst_idx", 64'(bus.predict_idx_o), 64'd0);
    chk("rst_tag", 64'(bus.predict_tag_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int r = 0; r < 9; r++) begin
      for (int k = 0; k < vt[r].reps; k++) begin
        bus.redirect_valid_i = vt[r].redir;
        bus.redirect_ghr_i   = vt[r].rghr;
        bus.redirect_taken_i = vt[r].rtaken;
        bus.push_valid_i     = vt[r].push;
        bus.push_taken_i     = vt[r].ptaken;
        bus.fetch_valid_i    = vt[r].fetch;
        bus.fetch_pc_i       = vt[r].pc;
        tick();
        set_idle();
      end
      chk($sformatf("v%0d_ghr", r), 64'(bus.ghr_o), 64'(vt[r].e_ghr));
      chk($sformatf("v%0d_pvalid", r), 64'(bus.predict_valid_o), 64'(vt[r].e_pv));
      if (vt[r].chk_idx) begin
        chk($sformatf("v%0d_idx0", r), 64'(bus.predict_idx_o[0]), 64'(vt[r].e_idx0));
        chk($sformatf("v%0d_tag0", r), 64'(bus.predict_tag_o[0]), 64'(vt[r].e_tag0));
        chk($sformatf("v%0d_idx1", r), 64'(bus.predict_idx_o[1]), 64'(vt[r].e_idx1));
      end
      check_model();
    end

    // Update path must match the predict hash for the same PC/history pair
    bus.update_pc_i  = 32'h8000_0000;
    bus.update_ghr_i = 16'h014A;
    #1;
    chk("upd_idx_dir", 64'(bus.update_idx_o), 64'h0F);
    chk("upd_tag_dir", 64'(bus.update_tag_o), 64'hDB);

    // Random run against the model
    for (int c = 0; c < 10000; c++) begin
      bus.redirect_valid_i = ($urandom_range(0, 15) == 0);
      bus.redirect_ghr_i   = 16'($urandom);
      bus.redirect_taken_i = 1'($urandom);
      bus.push_valid_i     = 1'($urandom);
      bus.push_taken_i     = 1'($urandom);
      bus.fetch_valid_i    = ($urandom_range(0, 3) != 0);
      pc = $urandom;
      if ($urandom_range(0, 7) == 0) pc = 32'hFFFF_FFF0 | (pc & 32'h0000_000C);
      bus.fetch_pc_i = pc;
      tick();
      check_model();
      bus.update_pc_i  = $urandom;
      bus.update_ghr_i = 16'($urandom);
      #1;
      chk("upd_idx", 64'(bus.update_idx_o), 64'(ref_idx(bus.update_pc_i, bus.update_ghr_i)));
      chk("upd_tag", 64'(bus.update_tag_o), 64'(ref_tag(bus.update_pc_i, bus.update_ghr_i)));
    end
    set_idle();

    // Asynchronous reset with a valid prediction showing
    bus.push_valid_i  = 1'b1;
    bus.push_taken_i  = 1'b1;
    bus.fetch_valid_i = 1'b1;
    bus.fetch_pc_i    = 32'h1234_5678;
    tick();
    set_idle();
    chk("pre_rst_pvalid", 64'(bus.predict_valid_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pvalid", 64'(bus.predict_valid_o), 64'd0);
    chk("arst_ghr", 64'(bus.ghr_o), 64'd0);
    chk("arst_idx", 64'(bus.predict_idx_o), 64'd0);
    chk("arst_tag", 64'(bus.predict_tag_o), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.fetch_valid_i = 1'b1;
    bus.fetch_pc_i    = 32'h8000_0000;
    tick();
    set_idle();
    for (int i = 0; i < NS; i++) begin
      chk($sformatf("post_rst_idx%0d", i), 64'(bus.predict_idx_o[i]), 64'(i));
      chk($sformatf("post_rst_tag%0d", i), 64'(bus.predict_tag_o[i]), 64'd0);
    end
    check_model();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
